// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package if_pkg;

    // Fixed-length instructions: each fetch advances the PC by one word.
    localparam int INST_BYTES = 4;

    // Sequential successor of a fetch address, wrapping at the top of the space.
    function automatic logic [63:0] next_pc64(input logic [63:0] pc);
        return pc + 64'(INST_BYTES);
    endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous FIFO with a single-cycle clear. The head is read combinationally,
// so a pushed word becomes visible at dout one cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and count update; clear discards every entry at once.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: issues in-order sequential fetches under a credit
// scheme that reserves a FIFO slot for every live in-flight request, buffers
// returns with their PCs and drops stale returns after a redirect.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      mem_req_valid,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [INST_W-1:0]         mem_resp_inst,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [INST_W-1:0]         out_inst,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = OW + CW;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [SW-1:0]     inflight;
    logic              req_fire;
    logic              resp_fire;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      fifo_din;
    fetch_entry_t      fifo_dout;

    // Entries held plus live (non-dropped) requests must stay below DEPTH so
    // every response that survives has a guaranteed slot.
    assign inflight      = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
    assign mem_req_valid = !rst && !redirect_valid
                         && (outstanding < OW'(MAX_OUT))
                         && (inflight < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses with nothing outstanding are strays from before a reset.
    assign resp_fire = mem_resp_valid && (outstanding != '0);
    assign fifo_push = resp_fire && (drop_cnt == '0) && !redirect_valid && !fifo_full;
    assign fifo_pop  = out_valid && out_ready;

    assign fifo_din.pc   = resp_pc;
    assign fifo_din.inst = mem_resp_inst;

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_dout.pc;
    assign out_inst  = fifo_dout.inst;
    assign occupancy = count;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch/response PCs and request bookkeeping; a redirect marks every
    // request still in flight after this cycle as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_fire);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= outstanding - OW'(resp_fire);
            end else begin
                if (req_fire)  fetch_pc <= ADDR_W'(next_pc64(64'(fetch_pc)));
                if (fifo_push) resp_pc  <= ADDR_W'(next_pc64(64'(resp_pc)));
                if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a 1-cycle in-order memory model
// whose responses can be held back to build up outstanding requests.
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_inst;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  occupancy;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic        hold;
    logic [31:0] pend[$];

    if_prefetch_unit #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    task automatic drive_mem();
        mem_resp_valid = !hold && (pend.size() != 0);
        mem_resp_inst  = mem_resp_valid ? inst_of(pend[0]) : 32'h0;
    endtask

    task automatic set_hold(input logic h);
        hold = h;
        drive_mem();
        #1;
    endtask

    // One clock: note what the edge will accept, then advance the memory model.
    task automatic tick();
        logic        fired;
        logic        rfire;
        logic [31:0] a;
        #1;
        fired = mem_req_valid && mem_req_ready;
        rfire = mem_resp_valid;
        a     = mem_req_addr;
        @(posedge clk);
        #1;
        if (rfire) void'(pend.pop_front());
        if (fired) pend.push_back(a);
        drive_mem();
        #1;
    endtask

    // Run n cycles, checking every accepted head against the expected stream.
    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (out_valid && out_ready) begin
                chk("seq_pc", out_pc, exp_pc);
                chk("seq_inst", out_inst, inst_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; out_ready = 1'b1; hold = 1'b0;
        drive_mem();
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_occ", {29'b0, occupancy}, 32'd0);

        // Sequential streaming, one instruction per cycle.
        rst = 1'b0; #1;
        chk("first_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("first_req_addr", mem_req_addr, 32'h0);
        tick();
        chk("second_req_addr", mem_req_addr, 32'h4);
        chk("no_bypass", {31'b0, out_valid}, 32'd0);
        tick();
        chk("out_valid_rise", {31'b0, out_valid}, 32'd1);
        exp_pc = 32'h0;
        consume(8);
        chk("throughput", exp_pc, 32'h20);

        // Backpressure: fill, freeze, then drain in order.
        out_ready = 1'b0; #1;
        held_pc = out_pc;
        for (int i = 0; i < 8; i++) tick();
        chk("full_occ", {29'b0, occupancy}, 32'd4);
        chk("full_no_req", {31'b0, mem_req_valid}, 32'd0);
        chk("freeze_pc", out_pc, held_pc);
        out_ready = 1'b1; #1;
        chk("full_still_no_req", {31'b0, mem_req_valid}, 32'd0);
        chk("full_head", out_pc, exp_pc);
        chk("full_head_inst", out_inst, inst_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        tick();
        chk("resume_req", {31'b0, mem_req_valid}, 32'd1);
        consume(8);
        chk("drain_cnt", exp_pc, 32'h44);

        // Redirect with two stale requests in flight.
        rst = 1'b1; tick(); rst = 1'b0;
        pend.delete(); set_hold(1'b0);
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        set_hold(1'b1);
        tick();
        chk("rd_max_out", {31'b0, mem_req_valid}, 32'd0);
        chk("rd_pre_occ", {29'b0, occupancy}, 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_occ", {29'b0, occupancy}, 32'd0);
        chk("rd_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        set_hold(1'b0);
        exp_pc = 32'h100;
        consume(6);
        chk("rd_cnt", exp_pc, 32'h10c);

        // Redirect coinciding with a response and an output handshake.
        redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("co_no_req", {31'b0, mem_req_valid}, 32'd0);
        chk("co_hs_valid", {31'b0, out_valid}, 32'd1);
        chk("co_hs_pc", out_pc, exp_pc);
        tick();
        redirect_valid = 1'b0; #1;
        chk("co_occ", {29'b0, occupancy}, 32'd0);
        chk("co_out_valid", {31'b0, out_valid}, 32'd0);
        chk("co_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("co_req_addr", mem_req_addr, 32'h200);
        exp_pc = 32'h200;
        consume(5);
        chk("co_cnt", exp_pc, 32'h20c);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0; #1;
        chk("wrap_a0", mem_req_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_a1", mem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_a2", mem_req_addr, 32'h0);
        exp_pc = 32'hFFFF_FFF8;
        consume(5);
        chk("wrap_cnt", exp_pc, 32'hC);

        // Reset with two requests outstanding, then stray responses.
        set_hold(1'b1);
        tick(); tick();
        chk("pre_rst_max_out", {31'b0, mem_req_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_req_ready = 1'b0;
        set_hold(1'b0);
        chk("post_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("post_rst_req_addr", mem_req_addr, 32'h0);
        tick(); tick();
        chk("stray_occ", {29'b0, occupancy}, 32'd0);
        chk("stray_out_valid", {31'b0, out_valid}, 32'd0);
        mem_req_ready = 1'b1;
        exp_pc = 32'h0;
        consume(5);
        chk("stray_cnt", exp_pc, 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
